// File: rtl/rrf_alloc_ctrl.sv
// rtl/rrf_alloc_ctrl.sv - rename register file tag allocation, commit reclamation and flush recovery
module rrf_alloc_ctrl #(
    parameter int RRF_ENT_NUM = 64,
    parameter int RRF_ENT_SEL = 6,
    parameter int CNT_W       = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_dp_req_1,
    input  logic                   i_dp_req_2,
    input  logic                   i_dp_stall,
    output logic                   o_alloc_ok,
    output logic [RRF_ENT_SEL-1:0] o_alloc_rrftag_1,
    output logic [RRF_ENT_SEL-1:0] o_alloc_rrftag_2,
    output logic                   o_rrf_full,
    output logic [CNT_W-1:0]       o_free_num,
    input  logic                   i_com_vld_1,
    input  logic                   i_com_vld_2,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_1,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_2,
    input  logic                   i_flush,
    input  logic [RRF_ENT_SEL-1:0] i_flush_rrftag
);
    logic [RRF_ENT_SEL-1:0] freeptr;
    logic [RRF_ENT_SEL-1:0] comptr;
    logic [RRF_ENT_SEL-1:0] comptr_nxt;
    logic [RRF_ENT_SEL-1:0] flush_dist;
    logic [RRF_ENT_SEL-1:0] flush_off;
    logic [CNT_W-1:0]       free_num;
    logic [CNT_W-1:0]       free_num_nxt;
    logic [CNT_W-1:0]       req_num;
    logic [CNT_W-1:0]       com_num;
    logic [CNT_W-1:0]       used_num;

    assign req_num = CNT_W'(i_dp_req_1) + CNT_W'(i_dp_req_2);
    assign com_num = CNT_W'(i_com_vld_1) + CNT_W'(i_com_vld_2);

    assign o_alloc_rrftag_1 = freeptr;
    assign o_alloc_rrftag_2 = freeptr + RRF_ENT_SEL'(i_dp_req_1);
    // Only the registered count is trusted; entries freed this cycle become usable next cycle.
    assign o_rrf_full = (free_num < req_num);
    assign o_alloc_ok = (req_num != '0) && !o_rrf_full && !i_dp_stall && !i_flush;
    assign o_free_num = free_num;

    assign o_com_ptr_1 = comptr;
    assign o_com_ptr_2 = comptr + RRF_ENT_SEL'(1);

    assign comptr_nxt = comptr + RRF_ENT_SEL'(com_num);
    assign flush_dist = i_flush_rrftag - comptr_nxt;
    assign flush_off  = i_flush_rrftag - comptr;
    assign used_num   = CNT_W'(RRF_ENT_NUM) - free_num;

    always_comb begin
        free_num_nxt = free_num + com_num - (o_alloc_ok ? req_num : '0);
        if (i_flush) begin
            // Surviving entries span comptr_nxt up to the flush tag; everything else is free.
            if (i_flush_rrftag == freeptr) begin
                free_num_nxt = free_num + com_num;
            end else begin
                free_num_nxt = CNT_W'(RRF_ENT_NUM) - CNT_W'(flush_dist);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            freeptr  <= '0;
            comptr   <= '0;
            free_num <= CNT_W'(RRF_ENT_NUM);
        end else begin
            if (i_flush) begin
                freeptr <= i_flush_rrftag;
            end else if (o_alloc_ok) begin
                freeptr <= freeptr + RRF_ENT_SEL'(req_num);
            end
            comptr   <= comptr_nxt;
            free_num <= free_num_nxt;
            assert (i_com_vld_1 || !i_com_vld_2);
            assert (com_num <= used_num);
            assert (!i_flush || (CNT_W'(flush_off) <= used_num));
        end
    end
endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// tb/tb_rrf_alloc_ctrl.sv - scoreboard bench for rrf_alloc_ctrl
module tb_rrf_alloc_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_dp_req_1, i_dp_req_2, i_dp_stall;
    logic       o_alloc_ok, o_rrf_full;
    logic [5:0] o_alloc_rrftag_1, o_alloc_rrftag_2;
    logic [6:0] o_free_num;
    logic       i_com_vld_1, i_com_vld_2;
    logic [5:0] o_com_ptr_1, o_com_ptr_2;
    logic       i_flush;
    logic [5:0] i_flush_rrftag;

    always #5 clk = ~clk;

    rrf_alloc_ctrl #(.RRF_ENT_NUM(64), .RRF_ENT_SEL(6), .CNT_W(7)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_dp_req_1      (i_dp_req_1),
        .i_dp_req_2      (i_dp_req_2),
        .i_dp_stall      (i_dp_stall),
        .o_alloc_ok      (o_alloc_ok),
        .o_alloc_rrftag_1(o_alloc_rrftag_1),
        .o_alloc_rrftag_2(o_alloc_rrftag_2),
        .o_rrf_full      (o_rrf_full),
        .o_free_num      (o_free_num),
        .i_com_vld_1     (i_com_vld_1),
        .i_com_vld_2     (i_com_vld_2),
        .o_com_ptr_1     (o_com_ptr_1),
        .o_com_ptr_2     (o_com_ptr_2),
        .i_flush         (i_flush),
        .i_flush_rrftag  (i_flush_rrftag)
    );

    typedef struct {
        string name;
        int    ok;
        int    full;
        int    t1;
        int    t2;
        int    free;
        int    cp;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input string field, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "alloc_ok", int'(o_alloc_ok), e.ok);
            chk(e.name, "rrf_full", int'(o_rrf_full), e.full);
            chk(e.name, "tag1", int'(o_alloc_rrftag_1), e.t1);
            chk(e.name, "tag2", int'(o_alloc_rrftag_2), e.t2);
            chk(e.name, "free_num", int'(o_free_num), e.free);
            chk(e.name, "com_ptr_1", int'(o_com_ptr_1), e.cp);
            chk(e.name, "com_ptr_2", int'(o_com_ptr_2), (e.cp + 1) % 64);
        end
    end

    task automatic step(input string name, input bit rst, input bit r1, input bit r2, input bit stall,
                        input bit c1, input bit c2, input bit fl, input int ftag,
                        input int e_ok, input int e_full, input int e_t1, input int e_t2,
                        input int e_free, input int e_cp);
        exp_t e;
        rst_n          = rst;
        i_dp_req_1     = r1;
        i_dp_req_2     = r2;
        i_dp_stall     = stall;
        i_com_vld_1    = c1;
        i_com_vld_2    = c2;
        i_flush        = fl;
        i_flush_rrftag = 6'(ftag);
        e.name = name; e.ok = e_ok; e.full = e_full; e.t1 = e_t1; e.t2 = e_t2;
        e.free = e_free; e.cp = e_cp;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; i_dp_req_1 = 0; i_dp_req_2 = 0; i_dp_stall = 0;
        i_com_vld_1 = 0; i_com_vld_2 = 0; i_flush = 0; i_flush_rrftag = '0;
        repeat (2) @(posedge clk);
        #1;
        //        name         rst r1 r2 st c1 c2 fl ftag  ok fu t1 t2 free cp
        step("reset_state",    1, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 1, 64, 0);
        step("first_pair",     1, 1, 1, 0, 0, 0, 0, 0,    1, 0, 0, 1, 64, 0);
        for (int i = 0; i < 30; i++)
            step($sformatf("fill%0d", i), 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 2 + 2*i, 3 + 2*i, 62 - 2*i, 0);
        step("lone_req2",      1, 0, 1, 0, 0, 0, 0, 0,    1, 0, 62, 62, 2, 0);
        step("full_deny",      1, 1, 1, 0, 0, 0, 0, 0,    0, 1, 63, 0, 1, 0);
        step("last_single",    1, 1, 0, 0, 0, 0, 0, 0,    1, 0, 63, 0, 1, 0);
        step("zero_commit2",   1, 1, 1, 0, 1, 1, 0, 0,    0, 1, 0, 1, 0, 0);
        step("wrap_realloc",   1, 1, 1, 0, 0, 0, 0, 0,    1, 0, 0, 1, 2, 2);
        step("flush_same_ptr", 1, 0, 0, 0, 1, 0, 1, 2,    0, 0, 2, 2, 0, 2);
        step("after_flush0",   1, 1, 1, 0, 0, 0, 0, 0,    0, 1, 2, 3, 1, 3);
        step("reset_midburst", 0, 1, 1, 0, 0, 0, 0, 0,    0, 1, 2, 3, 1, 3);
        step("post_reset",     1, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 1, 64, 0);
        for (int i = 0; i < 10; i++)
            step($sformatf("fill_b%0d", i), 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 2*i, 2*i + 1, 64 - 2*i, 0);
        step("commit2_a",      1, 0, 0, 0, 1, 1, 0, 0,    0, 0, 20, 20, 44, 0);
        step("commit2_b",      1, 0, 0, 0, 1, 1, 0, 0,    0, 0, 20, 20, 46, 2);
        step("commit1",        1, 0, 0, 0, 1, 0, 0, 0,    0, 0, 20, 20, 48, 4);
        step("flush_sup",      1, 1, 1, 0, 1, 0, 1, 10,   0, 0, 20, 21, 49, 5);
        step("after_flush",    1, 1, 1, 0, 0, 0, 0, 0,    1, 0, 10, 11, 60, 6);
        for (int i = 0; i < 25; i++)
            step($sformatf("fill_c%0d", i), 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 12 + 2*i, 13 + 2*i, 58 - 2*i, 6);
        step("req2_at62",      1, 0, 1, 0, 0, 0, 0, 0,    1, 0, 62, 62, 8, 6);
        step("wrap_pair",      1, 1, 1, 0, 0, 0, 0, 0,    1, 0, 63, 0, 7, 6);
        step("stall",          1, 1, 0, 1, 0, 0, 0, 0,    0, 0, 1, 2, 5, 6);
        step("flush_to_com",   1, 0, 0, 0, 0, 0, 1, 6,    0, 0, 1, 1, 5, 6);
        step("after_flush_e",  1, 1, 1, 0, 0, 0, 0, 0,    1, 0, 6, 7, 64, 6);
        step("alloc_commit",   1, 1, 1, 0, 1, 1, 0, 0,    1, 0, 8, 9, 62, 6);
        step("after_ac",       1, 1, 0, 1, 0, 0, 0, 0,    0, 0, 10, 11, 62, 8);
        @(negedge clk);
        #1;
        chk("drain", "queue_left", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
